// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared types and constants for the period meter.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, SYNC_STAGES synchroniser depth
// (used only when PERIOD_METER_SYNC_EN is defined).
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1,
    MEAS  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/rise_edge_detector.sv
// rise_edge_detector: one-cycle pulse on each rising edge of d.
// Latency: combinational from d by default; SYNC_STAGES clk later with PERIOD_METER_SYNC_EN.
// Backpressure: none, free-running.
// Ports: clk, resetn (async active-low), d (input level), rise_edge (pulse out).
// Optional PERIOD_METER_SYNC_EN: d passes through a reset-to-0 synchroniser first.
module rise_edge_detector
  import period_meter_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic rise_edge
);

  logic sig_s;
  logic sig_d;

`ifdef PERIOD_METER_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
`else
  assign sig_s = d;
`endif

  // History clears to 0, so an input already high out of reset yields one edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sig_d <= 1'b0;
    end else begin
      sig_d <= sig_s;
    end
  end

  assign rise_edge = sig_s & ~sig_d;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures clk cycles between consecutive rising edges of sig_in.
// Latency: done_tick the cycle after the second edge is seen (or after saturation).
// Backpressure: single-shot; start is accepted only while ready=1, otherwise dropped.
// Ports: clk, resetn, start, sig_in -> ready, done_tick, overflow, period[N-1:0].
// Optional PERIOD_METER_SYNC_EN (in rise_edge_detector) adds a 2-FF input synchroniser.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         sig_in,
  output logic         ready,
  output logic         done_tick,
  output logic         overflow,
  output logic [N-1:0] period
);

  localparam logic [N-1:0] CNT_MAX = '1;

  state_t       state, state_nxt;
  logic [N-1:0] cnt, cnt_nxt;
  logic [N-1:0] period_nxt;
  logic         overflow_nxt;
  logic         sig_edge;

  rise_edge_detector u_edge (
    .clk       (clk),
    .resetn    (resetn),
    .d         (sig_in),
    .rise_edge (sig_edge)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      period   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      period   <= period_nxt;
      overflow <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    period_nxt   = period;
    overflow_nxt = overflow;
    case (state)
      // Edges seen in IDLE (including one coinciding with start) are ignored.
      IDLE: begin
        if (start) state_nxt = WAIT1;
      end
      WAIT1: begin
        if (sig_edge) begin
          cnt_nxt   = '0;
          state_nxt = MEAS;
        end
      end
      // cnt holds (cycles since first edge) - 1, hence the +1 on capture.
      // Saturation wins over a coincident edge: a period of 2**N is not representable.
      MEAS: begin
        if (cnt == CNT_MAX) begin
          period_nxt   = CNT_MAX;
          overflow_nxt = 1'b1;
          state_nxt    = DONE;
        end else if (sig_edge) begin
          period_nxt   = cnt + N'(1);
          overflow_nxt = 1'b0;
          state_nxt    = DONE;
        end else begin
          cnt_nxt = cnt + N'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign ready     = (state == IDLE);
  assign done_tick = (state == DONE);

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed bench for period_meter at N=16 and N=4 sharing one stimulus.
// Latency: expected done_tick timing shifts by 2 clk when PERIOD_METER_SYNC_EN is defined.
// Backpressure: n/a.
module tb_period_meter;

`ifdef PERIOD_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk;
  logic        resetn;
  logic        start;
  logic        sig_in;
  logic        ready16, done16, ovf16;
  logic [15:0] period16;
  logic        ready4, done4, ovf4;
  logic [3:0]  period4;

  int errors = 0;
  int checks = 0;

  int done16_at, done4_at, done16_cnt;
  logic rdy_at_done, rdy_after;

  period_meter #(.N(16)) dut16 (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .sig_in    (sig_in),
    .ready     (ready16),
    .done_tick (done16),
    .overflow  (ovf16),
    .period    (period16)
  );

  period_meter #(.N(4)) dut4 (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .sig_in    (sig_in),
    .ready     (ready4),
    .done_tick (done4),
    .overflow  (ovf4),
    .period    (period4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One-clk pulses on sig_in every per cycles for budget cycles; start is
  // pulsed at iteration start_at (-1 = never). Records done_tick timing.
  task automatic run(input int per, input int budget, input int start_at);
    done16_at   = -1;
    done4_at    = -1;
    done16_cnt  = 0;
    rdy_at_done = 1'bx;
    rdy_after   = 1'bx;
    for (int c = 0; c < budget; c++) begin
      sig_in = ((c % per) == 0);
      start  = (c == start_at);
      @(posedge clk); #1;
      if (done16) begin
        done16_cnt++;
        if (done16_at < 0) begin
          done16_at   = c;
          rdy_at_done = ready16;
        end
      end
      if (done16_at >= 0 && c == done16_at + 1) rdy_after = ready16;
      if (done4 && done4_at < 0) done4_at = c;
    end
    sig_in = 1'b0;
    start  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    sig_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_period", period16, 0);
    check("rst_ovf", ovf16, 0);
    check("rst_done", done16, 0);
    check("rst_ready", ready16, 1);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready", ready16, 1);

    // Pulse every 10 clk.
    do_start();
    check("start_accepted", ready16, 0);
    run(10, 30, -1);
    check("p10_done_at", done16_at, 10 + LAT);
    check("p10_done_cnt", done16_cnt, 1);
    check("p10_period", period16, 10);
    check("p10_ovf", ovf16, 0);
    check("p10_rdy_at_done", rdy_at_done, 0);
    check("p10_rdy_after", rdy_after, 1);
    check("p10_n4_period", period4, 10);
    check("p10_n4_ovf", ovf4, 0);

    // Toggling every clk: minimum period.
    do_start();
    run(2, 12, -1);
    check("p2_done_at", done16_at, 2 + LAT);
    check("p2_period", period16, 2);
    check("p2_ovf", ovf16, 0);

    // Long period; N=4 saturates.
    do_start();
    run(1000, 2100, -1);
    check("p1000_done_at", done16_at, 1000 + LAT);
    check("p1000_period", period16, 1000);
    check("p1000_ovf", ovf16, 0);
    check("p1000_n4_ovf", ovf4, 1);
    check("p1000_n4_period", period4, 15);
    check("p1000_n4_done_at", done4_at, 16 + LAT);

    // Period 20 at N=4: overflow, done 16 cycles after the first edge.
    do_start();
    run(20, 50, -1);
    check("p20_n4_done_at", done4_at, 16 + LAT);
    check("p20_n4_ovf", ovf4, 1);
    check("p20_n4_period", period4, 15);
    check("p20_period", period16, 20);
    check("p20_ovf", ovf16, 0);

    // start during MEAS is ignored.
    do_start();
    run(10, 30, 5);
    check("mstart_done_cnt", done16_cnt, 1);
    check("mstart_period", period16, 10);
    check("mstart_n4_ovf", ovf4, 0);

    // Reset in the middle of MEAS.
    do_start();
    run(10, 5, -1);
    check("mid_busy", ready16, 0);
    resetn = 1'b0;
    #1;
    check("mid_rst_period", period16, 0);
    check("mid_rst_ovf", ovf16, 0);
    check("mid_rst_ready", ready16, 1);
    check("mid_rst_done", done16, 0);
    check("mid_rst_n4_period", period4, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    run(10, 30, -1);
    check("post_rst_no_done", done16_cnt, 0);
    check("post_rst_ready", ready16, 1);
    check("post_rst_period", period16, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
